full_adder_4bit: RTL and testbench
==================================

# full_adder_4bit

Registered 4-bit ripple-carry adder with carry-in and carry-out. It adds two 4-bit unsigned operands and a carry-in, and registers the 4-bit sum, carry-out and a signed-overflow flag on the clock edge. It is the arithmetic building block used by the gate-level circuit-simulator regression designs, and it is built from single-bit full-adder cells.

## Interface
- No parameters; width fixed at 4 bits.
- One clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock; all state updates on this edge only.
- rst  input  1  synchronous active-high reset.
- a  input  4  operand A, unsigned; bit 0 is the LSB.
- b  input  4  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  4  registered (a + b + cin) mod 16.
- cout  output  1  registered carry out of bit 3 ((a + b + cin) ≥ 16).
- ovf  output  1  registered two's-complement overflow: carry into bit 3 XOR carry out of bit 3.

## Operation
- Datapath: four 1-bit full-adder cells chained c0 = cin, c(i+1) = carry of cell i.
- Cell i: s_i = a_i ^ b_i ^ c_i; c(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)).
- Carry chain is purely combinational, with no internal registers between cells.
- Next-state values are the 5-bit result {cout, sum} = a + b + cin, and ovf = c3 ^ c4.
- Full range: the 5-bit result covers 0..31; maximum input is 15 + 15 + 1 = 31, giving sum = 15 and cout = 1.
- Wrap-around: a result of 16 gives sum = 0, cout = 1.
- No input handshake; operands are sampled on every rising edge.
- Inputs are assumed stable around the clock edge. X or Z on an input propagates to the outputs; no masking.

## Timing
- Latency is 1 clock: the values present on a, b and cin at rising edge N appear on sum, cout and ovf after edge N and hold until edge N+1.
- Throughput is one addition per clock; back-to-back operand changes every cycle are supported.
- Reset: when rst = 1 at a rising edge, sum = 4'b0000, cout = 0 and ovf = 0 after that edge. Operands are ignored while rst is high.
- Before the first clock edge with rst asserted, the output values are undefined.
- Reset deasserted: the first valid result appears one edge after rst falls, computed from the operands at that edge.
- Reset asserted mid-stream: any in-flight result is discarded at that edge and outputs go to zero. There is no partial update.
- Outputs never change between clock edges: changes on a, b or cin between edges must not glitch sum, cout or ovf.

## Test plan
- Reset: hold rst = 1 for 2 cycles with a = 4'b1111, b = 4'b1111, cin = 1 -> sum = 0, cout = 0, ovf = 0 after each edge.
- Basic add: a = 1, b = 2, cin = 0, one clock -> sum = 3, cout = 0, ovf = 0.
- Carry wrap: a = 15, b = 1, cin = 0 -> sum = 0, cout = 1, ovf = 0.
- Carry-in wrap: a = 5, b = 10, cin = 1 -> sum = 0, cout = 1, ovf = 0.
- Signed overflow and maximum: a = 7, b = 1, cin = 0 -> sum = 8, cout = 0, ovf = 1; next cycle a = 15, b = 15, cin = 1 -> sum = 15, cout = 1, ovf = 0.
- Exhaustive sweep: all 512 combinations of a, b and cin applied back-to-back, one per clock.
  - Each result is checked one cycle later against {cout, sum} = a + b + cin and ovf = (a[3] == b[3]) && (sum[3] != a[3]).
  - Reset is pulsed once mid-sweep; the cycle after the pulse must read zero, then checking resumes with the next operands.

Source files
------------

// File: rtl/full_adder_4bit.sv
// Purpose : registered 4-bit ripple-carry adder (sum, carry-out, signed overflow).
// Latency : 1 clock from operands sampled at a rising edge to registered outputs.
// Backpressure: none; operands are taken on every rising edge, one add per clock.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; clears sum/cout/ovf
//   a, b - 4-bit unsigned operands (bit 0 = LSB)
//   cin  - carry into bit 0
//   sum  - registered (a + b + cin) mod 16
//   cout - registered carry out of bit 3
//   ovf  - registered two's-complement overflow (carry into bit 3 ^ carry out)

// Single-bit full-adder cell used to build the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovf
);
  // carry[i] is the carry into bit i; carry[4] is the carry out of bit 3.
  logic [4:0] carry;
  logic [3:0] sum_nxt;
  logic       ovf_nxt;

  assign carry[0] = cin;

  // Purely combinational ripple chain; no registers between cells.
  for (genvar i = 0; i < 4; i++) begin : g_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_nxt[i]),
      .co (carry[i+1])
    );
  end

  // Signed overflow: the MSB cell's carry-in disagrees with its carry-out.
  assign ovf_nxt = carry[3] ^ carry[4];

  // Outputs are only ever updated on the clock edge, so operand changes
  // between edges cannot glitch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= 4'b0000;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      sum  <= sum_nxt;
      cout <= carry[4];
      ovf  <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_full_adder_4bit.sv
// Purpose : self-checking bench for full_adder_4bit (directed vectors + full sweep).
// Latency : expects results one clock after operands are applied.
// Backpressure: none; operands driven every cycle.
module tb_full_adder_4bit;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;

  int n_chk;
  int n_pass;

  full_adder_4bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply operands, clock once, then check all three outputs.
  task automatic vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                     input logic vc, input logic [3:0] es, input logic ec, input logic eo);
    a   = va;
    b   = vb;
    cin = vc;
    tick();
    check({tag, ".sum"},  {4'b0, sum},  {4'b0, es});
    check({tag, ".cout"}, {7'b0, cout}, {7'b0, ec});
    check({tag, ".ovf"},  {7'b0, ovf},  {7'b0, eo});
  endtask

  initial begin
    logic [3:0] sa, sb;
    logic       sc;
    logic [4:0] r;
    logic       eo;
    logic [3:0] held;

    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;

    // Reset held for two edges with maximal operands present.
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst%0d.sum", k),  {4'b0, sum},  8'h00);
      check($sformatf("rst%0d.cout", k), {7'b0, cout}, 8'h00);
      check($sformatf("rst%0d.ovf", k),  {7'b0, ovf},  8'h00);
    end
    rst = 1'b0;

    // Directed vectors, expected values worked by hand.
    vec("basic",    4'd1,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0);
    vec("wrap",     4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0);
    vec("cinwrap",  4'd5,  4'd10, 1'b1, 4'd0,  1'b1, 1'b0);
    vec("sovf",     4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1);
    vec("max",      4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
    vec("negovf",   4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1);
    vec("negok",    4'd12, 4'd14, 1'b0, 4'd10, 1'b1, 1'b0);

    // Operand change between edges must not disturb registered outputs.
    held = sum;
    a = 4'd3;
    b = 4'd4;
    cin = 1'b1;
    #3;
    check("hold.sum", {4'b0, sum}, 8'h0A);
    check("hold.cout", {7'b0, cout}, 8'h01);
    check("hold.same", {4'b0, sum}, {4'b0, held});
    tick();
    check("hold.next", {4'b0, sum}, 8'h08);

    // Exhaustive sweep, with a reset pulse at the midpoint.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = i[8:0];
      sc = iv[8];
      sa = iv[7:4];
      sb = iv[3:0];
      if (i == 256) begin
        rst = 1'b1;
        a   = sa;
        b   = sb;
        cin = sc;
        tick();
        check("midrst", {2'b0, ovf, cout, sum}, 8'h00);
        rst = 1'b0;
      end
      a   = sa;
      b   = sb;
      cin = sc;
      tick();
      r  = {1'b0, sa} + {1'b0, sb} + {4'b0, sc};
      eo = (sa[3] == sb[3]) && (r[3] != sa[3]);
      check($sformatf("sweep a=%0d b=%0d c=%0d", sa, sb, sc),
            {2'b0, ovf, cout, sum}, {2'b0, eo, r});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
